// File: rtl/mux_rr_reg.sv
// N-to-1 valid/ready multiplexer with a single registered output beat.
// Arbitration is either an externally supplied select (mode = 0) or
// round-robin over the valid inputs (mode = 1). One beat per cycle, one
// cycle of latency. The output register is the only storage besides the
// round-robin pointer.
module mux_rr_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             fix_vld;
    logic             hi_vld, lo_vld;
    logic [SELW-1:0]  hi_idx, lo_idx;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             load_ok;
    logic             accept;

    // Fixed-mode grant: only a select that names an existing, valid channel wins.
    always_comb begin
        fix_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (SELW'(i) == sel && in_valid[i]) begin
                fix_vld = 1'b1;
            end
        end
    end

    // Round-robin search: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SELW'(i);
                if (SELW'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = SELW'(i);
                end
            end
        end
    end

    // Pick the active arbiter, then derive ready and the accept strobe.
    always_comb begin
        if (mode) begin
            grant_vld = lo_vld;
            grant_idx = hi_vld ? hi_idx : lo_idx;
        end else begin
            grant_vld = fix_vld;
            grant_idx = sel;
        end
        load_ok = !out_valid_q || out_ready;
        accept  = grant_vld && load_ok && !rst;
    end

    // One-hot ready towards the granted channel and its data word.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and pointer next state: load, drain or hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_data_d  = grant_data;
            out_valid_d = 1'b1;
            out_ch_d    = grant_idx;
            // Only round-robin accepts advance fairness; fixed accepts leave it alone.
            if (mode) begin
                ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;

endmodule
